// File: rtl/eval_pkg.sv
// Shared types and constants for the evaluation dispatcher and its frame FIFO.
package eval_pkg;

    localparam int unsigned DropCntW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    function automatic int unsigned frame_width(input int unsigned nch, input int unsigned iw,
                                                input int unsigned p);
        return nch * (iw + p);
    endfunction

endpackage

// File: rtl/eval_frame_fifo.sv
// Synchronous frame FIFO; Depth must be a power of two so the pointers wrap naturally.
module eval_frame_fifo #(
    parameter int unsigned DataW = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DataW-1:0]           wdata_i,
    output logic [DataW-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned LevelW = $clog2(Depth + 1);

    logic [DataW-1:0]  mem_q [Depth];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LevelW'(Depth));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
        if (do_push && !do_pop)      level_d = level_q + LevelW'(1);
        else if (!do_push && do_pop) level_d = level_q - LevelW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/eval_dispatch.sv
// Buffers complex frames and hands them one at a time to a downstream evaluator,
// with zero-frame filtering, drop counting and a watchdog on the evaluator.
module eval_dispatch
    import eval_pkg::*;
#(
    parameter int unsigned P       = 22,
    parameter int unsigned IW      = 3,
    parameter int unsigned NCH     = 6,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023,
    localparam int unsigned W      = frame_width(NCH, IW, P)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [W-1:0]               cur_data_real_i,
    input  logic [W-1:0]               cur_data_imag_i,
    input  logic                       skip_zero_i,
    input  logic                       eval_done_i,
    output logic [W-1:0]               cur_data_real_o,
    output logic [W-1:0]               cur_data_imag_o,
    output logic                       eval_start_o,
    output logic                       eval_busy_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
    output logic [DropCntW-1:0]        drop_cnt_o,
    output logic                       timeout_o
);

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic [WdW-1:0]      wd_cnt_q, wd_cnt_d;
    logic [W-1:0]        real_q, real_d, imag_q, imag_d;
    logic                timeout_q, timeout_d;
    logic [DropCntW-1:0] drop_q, drop_d;
    logic                fifo_full, fifo_empty;
    logic                accept, frame_nonzero, push, pop;
    logic [2*W-1:0]      head;

    // Ready looks only at registered full, so a pop never frees a slot in the same cycle.
    assign in_ready_o    = ~fifo_full & ~rst;
    assign accept        = in_valid_i & in_ready_o;
    assign frame_nonzero = (cur_data_real_i != '0) && (cur_data_imag_i != '0);
    assign push          = accept & (~skip_zero_i | frame_nonzero);
    assign pop           = (state_q == StIdle) & ~fifo_empty;

    eval_frame_fifo #(
        .DataW (2 * W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cur_data_imag_i, cur_data_real_i}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    always_comb begin
        drop_d = drop_q;
        if (in_valid_i && !in_ready_o && !rst && drop_q != '1) drop_d = drop_q + DropCntW'(1);
    end

    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        real_d    = real_q;
        imag_d    = imag_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    real_d  = head[W-1:0];
                    imag_d  = head[2*W-1:W];
                    state_d = StStart;
                end
            end
            StStart: begin
                wd_cnt_d = '0;
                state_d  = eval_done_i ? StIdle : StWait;
            end
            StWait: begin
                // Done takes priority over a watchdog expiry on the same edge.
                if (eval_done_i) begin
                    state_d = StIdle;
                end else if (TIMEOUT != 0 && wd_cnt_q == WdLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WdW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wd_cnt_q  <= '0;
            real_q    <= '0;
            imag_q    <= '0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            real_q    <= real_d;
            imag_q    <= imag_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    assign cur_data_real_o = real_q;
    assign cur_data_imag_o = imag_q;
    assign eval_start_o    = (state_q == StStart);
    assign eval_busy_o     = (state_q != StIdle);
    assign timeout_o       = timeout_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_eval_dispatch.sv
// Directed bench for eval_dispatch; a scoreboard queue holds frames expected at each start pulse.
module tb_eval_dispatch;

    localparam int unsigned P       = 22;
    localparam int unsigned IW      = 3;
    localparam int unsigned NCH     = 6;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned W       = NCH * (IW + P);

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] cur_data_real_i, cur_data_imag_i;
    logic         skip_zero_i;
    logic         eval_done_i;
    logic [W-1:0] cur_data_real_o, cur_data_imag_o;
    logic         eval_start_o, eval_busy_o, timeout_o;
    logic [$clog2(DEPTH+1)-1:0] fifo_level_o;
    logic [15:0]  drop_cnt_o;

    frame_t sb[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int n_start   = 0;
    int n_timeout = 0;

    eval_dispatch #(
        .P       (P),
        .IW      (IW),
        .NCH     (NCH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .cur_data_real_i (cur_data_real_i),
        .cur_data_imag_i (cur_data_imag_i),
        .skip_zero_i     (skip_zero_i),
        .eval_done_i     (eval_done_i),
        .cur_data_real_o (cur_data_real_o),
        .cur_data_imag_o (cur_data_imag_o),
        .eval_start_o    (eval_start_o),
        .eval_busy_o     (eval_busy_o),
        .fifo_level_o    (fifo_level_o),
        .drop_cnt_o      (drop_cnt_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] re, input logic [W-1:0] im, input bit exp_push);
        in_valid_i      = 1'b1;
        cur_data_real_i = re;
        cur_data_imag_i = im;
        @(posedge clk);
        if (exp_push) sb.push_back('{re: re, im: im});
        #1;
        in_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (eval_start_o === 1'b1) begin
            frame_t f;
            n_start++;
            if (sb.size() == 0) begin
                chk("unexpected_start", eval_start_o, 0);
            end else begin
                f = sb.pop_front();
                chk("start_real", cur_data_real_o, f.re);
                chk("start_imag", cur_data_imag_o, f.im);
            end
        end
        if (timeout_o === 1'b1) n_timeout++;
    end

    initial begin
        #100000;
        $display("FAIL bench_time_limit: observed no end expected end of test");
        $fatal(1, "time limit");
    end

    initial begin
        logic [W-1:0] f_one, re, im;
        int base_start, base_timeout;
        f_one           = {6{25'h1}};
        rst             = 1'b1;
        in_valid_i      = 1'b0;
        cur_data_real_i = '0;
        cur_data_imag_i = '0;
        skip_zero_i     = 1'b0;
        eval_done_i     = 1'b0;
        step();
        step();
        chk("rst_ready", in_ready_o, 0);
        chk("rst_start", eval_start_o, 0);
        chk("rst_busy", eval_busy_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_real", cur_data_real_o, 0);
        chk("rst_imag", cur_data_imag_o, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready_o, 1);

        // Single frame, done raised for the edge 5 cycles after the start cycle.
        offer(f_one, f_one, 1'b1);
        chk("sf_level_push", fifo_level_o, 1);
        chk("sf_no_start_yet", eval_start_o, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sf_start", eval_start_o, i == 0);
            chk("sf_busy", eval_busy_o, 1);
        end
        chk("sf_level_pop", fifo_level_o, 0);
        eval_done_i = 1'b1;
        step();
        eval_done_i = 1'b0;
        chk("sf_busy_drop", eval_busy_o, 0);
        chk("sf_hold_real", cur_data_real_o, f_one);
        chk("sf_hold_imag", cur_data_imag_o, f_one);
        chk("sf_starts", n_start, 1);

        // Zero filter.
        skip_zero_i = 1'b1;
        offer(W'(0), W'(5), 1'b0);
        chk("zf_level_a", fifo_level_o, 0);
        offer(W'(3), W'(0), 1'b0);
        chk("zf_level_b", fifo_level_o, 0);
        offer(W'(3), W'(5), 1'b1);
        chk("zf_level_c", fifo_level_o, 1);
        step();
        chk("zf_start", eval_start_o, 1);
        step();
        chk("zf_starts", n_start, 2);
        eval_done_i = 1'b1;
        step();
        eval_done_i = 1'b0;
        chk("zf_idle", eval_busy_o, 0);

        // Filter disabled; done during START returns straight to idle.
        skip_zero_i = 1'b0;
        offer(W'(0), W'(0), 1'b1);
        chk("nf_level", fifo_level_o, 1);
        step();
        chk("nf_start", eval_start_o, 1);
        chk("nf_real_zero", cur_data_real_o, 0);
        eval_done_i = 1'b1;
        step();
        eval_done_i = 1'b0;
        chk("nf_idle", eval_busy_o, 0);
        chk("nf_starts", n_start, 3);

        // Fill and overflow: 7 frames back to back, evaluator silent.
        for (int k = 0; k < 7; k++) begin
            re = W'(k + 1) << (k * 20);
            im = ~re;
            offer(re, im, k < 5);
        end
        chk("ov_ready", in_ready_o, 0);
        chk("ov_level", fifo_level_o, 4);
        chk("ov_drop", drop_cnt_o, 2);
        chk("ov_busy", eval_busy_o, 1);
        chk("ov_starts", n_start, 4);

        // Watchdog: start cycle S was 5 cycles ago; expiry shows in cycle S+16.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wd_no_timeout", timeout_o, 0);
            chk("wd_busy", eval_busy_o, 1);
        end
        step();
        chk("wd_timeout", timeout_o, 1);
        chk("wd_busy_drop", eval_busy_o, 0);
        step();
        chk("wd_pulse_len", timeout_o, 0);
        chk("wd_next_start", eval_start_o, 1);
        chk("wd_level", fifo_level_o, 3);
        chk("wd_ready", in_ready_o, 1);

        // Done on the last WAIT cycle beats the watchdog.
        for (int i = 0; i < 15; i++) begin
            step();
            chk("dt_busy", eval_busy_o, 1);
        end
        eval_done_i = 1'b1;
        step();
        eval_done_i = 1'b0;
        chk("dt_no_timeout", timeout_o, 0);
        chk("dt_idle", eval_busy_o, 0);
        chk("dt_timeouts", n_timeout, 1);

        // Reset mid-WAIT with 3 frames queued.
        step();
        chk("mr_start", eval_start_o, 1);
        offer(f_one, ~f_one, 1'b1);
        chk("mr_level", fifo_level_o, 3);
        step();
        chk("mr_wait", eval_busy_o, 1);
        rst = 1'b1;
        step();
        chk("mr_ready", in_ready_o, 0);
        chk("mr_busy", eval_busy_o, 0);
        chk("mr_level0", fifo_level_o, 0);
        chk("mr_drop", drop_cnt_o, 0);
        chk("mr_real", cur_data_real_o, 0);
        chk("mr_imag", cur_data_imag_o, 0);
        chk("mr_timeout", timeout_o, 0);
        rst = 1'b0;
        sb.delete();
        base_start   = n_start;
        base_timeout = n_timeout;
        for (int i = 0; i < 20; i++) step();
        chk("mr_quiet_start", n_start, base_start);
        chk("mr_quiet_timeout", n_timeout, base_timeout);
        chk("mr_quiet_level", fifo_level_o, 0);
        offer(W'(7), W'(9), 1'b1);
        step();
        chk("mr_new_start", eval_start_o, 1);
        eval_done_i = 1'b1;
        step();
        eval_done_i = 1'b0;
        step();
        chk("mr_new_starts", n_start, base_start + 1);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
